// File: rtl/plab5_mcore_dma_req_frontend_pkg.sv
// Shared definitions for the DMA request front-end: message field encodings,
// register offsets, status codes and FSM state encodings.
package plab5_mcore_dma_req_frontend_pkg;

    // Memory message type field (vc mem msg format)
    localparam int         c_type_nbits = 3;
    localparam logic [2:0] c_type_read  = 3'd0;
    localparam logic [2:0] c_type_write = 3'd1;

    // Register offsets, taken from addr[3:2]
    localparam logic [1:0] c_off_src   = 2'd0;
    localparam logic [1:0] c_off_dest  = 2'd1;
    localparam logic [1:0] c_off_go    = 2'd2;
    localparam logic [1:0] c_off_count = 2'd3;

    // Status codes returned in resp_data; the top expands them to full width
    typedef enum logic [1:0] {
        STATUS_OK       = 2'd0,   // 0
        STATUS_REJECT   = 2'd1,   // 1
        STATUS_UNMAPPED = 2'd2    // all ones
    } status_t;

    // Front-end control FSM
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP     = 2'd1,
        ST_LAUNCH   = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    // A domain-0 GO may not use an address last written by domain 1.
    // Domain-1 GOs are always allowed.
    function automatic logic go_rejected(input logic req_dom,
                                         input logic src_tag,
                                         input logic dest_tag);
        return (req_dom == 1'b0) && (src_tag || dest_tag);
    endfunction

endpackage

// File: rtl/plab5_mcore_dma_tagged_reg.sv
// Address register with a 1-bit tag recording the security domain of its
// last writer. Data and tag are always updated together.
module plab5_mcore_dma_tagged_reg #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wen,
    input  logic [p_nbits-1:0] i_data,
    input  logic               i_tag,
    output logic [p_nbits-1:0] o_data,
    output logic               o_tag
);

    logic [p_nbits-1:0] r_data;
    logic               r_tag;

    // Capture value and writer domain on write enable; clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_tag  <= 1'b0;
        end else if (i_wen) begin
            r_data <= i_data;
            r_tag  <= i_tag;
        end
    end

    assign o_data = r_data;
    assign o_tag  = r_tag;

endmodule

// File: rtl/plab5_mcore_dma_req_frontend.sv
// Memory-mapped front-end for the DMA controller. Holds SRC/DEST (domain
// tagged), launches one DMA copy per GO write and answers every accepted
// network request with exactly one response. One request in flight at a time.
module plab5_mcore_dma_req_frontend
    import plab5_mcore_dma_req_frontend_pkg::*;
#(
    parameter int                    p_opaque_nbits = 8,
    parameter int                    p_addr_nbits   = 32,
    parameter int                    p_data_nbits   = 32,
    parameter logic [p_addr_nbits-1:0] p_base_addr  = 32'h0002_0000,
    localparam int c_len_nbits   = $clog2(p_data_nbits / 8),
    localparam int c_req_cnbits  = c_type_nbits + p_opaque_nbits + p_addr_nbits + c_len_nbits,
    localparam int c_resp_cnbits = c_type_nbits + p_opaque_nbits + c_len_nbits
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic [c_req_cnbits-1:0]  req_control,
    input  logic [p_data_nbits-1:0]  req_data,
    input  logic                     req_domain,

    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic [c_resp_cnbits-1:0] resp_control,
    output logic [p_data_nbits-1:0]  resp_data,
    output logic                     resp_domain,

    output logic                     dma_val,
    input  logic                     dma_rdy,
    output logic                     dma_domain,
    output logic [p_addr_nbits-1:0]  dma_src_addr,
    output logic [p_addr_nbits-1:0]  dma_dest_addr,
    input  logic                     dma_ack
);

    // ------------------------------------------------------------------
    // Request unpack: {type, opaque, addr, len}
    // ------------------------------------------------------------------
    logic [c_type_nbits-1:0]   w_req_type;
    logic [p_opaque_nbits-1:0] w_req_opaque;
    logic [p_addr_nbits-1:0]   w_req_addr;
    logic [c_len_nbits-1:0]    w_req_len;

    assign w_req_type   = req_control[c_req_cnbits-1 -: c_type_nbits];
    assign w_req_opaque = req_control[c_req_cnbits-c_type_nbits-1 -: p_opaque_nbits];
    assign w_req_addr   = req_control[c_len_nbits +: p_addr_nbits];
    assign w_req_len    = req_control[c_len_nbits-1:0];

    // Length and byte offset carry no meaning for word-wide registers
    logic w_unused_req_bits;
    assign w_unused_req_bits = ^{w_req_len, w_req_addr[1:0]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                    r_state;
    logic                      r_req_rdy;
    logic                      r_resp_val;
    logic [p_data_nbits-1:0]   r_resp_data;
    logic                      r_resp_domain;
    logic [c_type_nbits-1:0]   r_resp_type;
    logic [p_opaque_nbits-1:0] r_resp_opaque;
    logic                      r_dma_val;
    logic                      r_dma_domain;
    logic [p_addr_nbits-1:0]   r_dma_src;
    logic [p_addr_nbits-1:0]   r_dma_dest;
    logic [p_data_nbits-1:0]   r_count;

    // Request fields held while a GO transfer is in progress
    logic [c_type_nbits-1:0]   r_lat_type;
    logic [p_opaque_nbits-1:0] r_lat_opaque;
    logic                      r_lat_domain;

    // ------------------------------------------------------------------
    // Tagged SRC (index 0) and DEST (index 1) registers
    // ------------------------------------------------------------------
    logic [1:0]              w_reg_wen;
    logic [p_addr_nbits-1:0] w_reg_data [2];
    logic [1:0]              w_reg_tag;

    for (genvar gi = 0; gi < 2; gi++) begin : g_addr_reg
        plab5_mcore_dma_tagged_reg #(
            .p_nbits (p_addr_nbits)
        ) u_reg (
            .clk    (clk),
            .reset  (reset),
            .i_wen  (w_reg_wen[gi]),
            .i_data (p_addr_nbits'(req_data)),
            .i_tag  (req_domain),
            .o_data (w_reg_data[gi]),
            .o_tag  (w_reg_tag[gi])
        );
    end

    // ------------------------------------------------------------------
    // Decode of the request presented in IDLE
    // ------------------------------------------------------------------
    function automatic logic [p_data_nbits-1:0] status_word(input status_t s);
        case (s)
            STATUS_OK:     return '0;
            STATUS_REJECT: return p_data_nbits'(1);
            default:       return '1;
        endcase
    endfunction

    logic                    w_accept;
    logic                    w_is_write;
    logic                    w_hit;
    logic [1:0]              w_off;
    logic                    w_mapped;
    logic                    w_go_write;
    logic                    w_go_reject;
    logic [p_data_nbits-1:0] w_resp_word;

    assign w_accept    = req_val && r_req_rdy;
    assign w_is_write  = (w_req_type == c_type_write);
    assign w_hit       = (w_req_addr[p_addr_nbits-1:4] == p_base_addr[p_addr_nbits-1:4]);
    assign w_off       = w_req_addr[3:2];
    // COUNT is read-only: a write to it behaves like a miss
    assign w_mapped    = w_hit && !(w_is_write && (w_off == c_off_count));
    assign w_go_write  = w_mapped && w_is_write && (w_off == c_off_go);
    assign w_go_reject = go_rejected(req_domain, w_reg_tag[0], w_reg_tag[1]);

    // Register write enables and the response word for a directly answered request
    always_comb begin
        w_reg_wen   = 2'b00;
        w_resp_word = '0;
        if (w_accept && w_mapped && w_is_write) begin
            w_reg_wen[0] = (w_off == c_off_src);
            w_reg_wen[1] = (w_off == c_off_dest);
        end
        if (!w_mapped) begin
            w_resp_word = status_word(STATUS_UNMAPPED);
        end else if (w_is_write) begin
            w_resp_word = (w_go_write && w_go_reject) ? status_word(STATUS_REJECT)
                                                      : status_word(STATUS_OK);
        end else begin
            case (w_off)
                c_off_src:   w_resp_word = p_data_nbits'(w_reg_data[0]);
                c_off_dest:  w_resp_word = p_data_nbits'(w_reg_data[1]);
                c_off_go:    w_resp_word = '0;
                default:     w_resp_word = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. Every output not owned by the
    // current state is held at zero so IDLE presents a clean interface.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_rdy     <= 1'b1;
            r_resp_val    <= 1'b0;
            r_resp_data   <= '0;
            r_resp_domain <= 1'b0;
            r_resp_type   <= '0;
            r_resp_opaque <= '0;
            r_dma_val     <= 1'b0;
            r_dma_domain  <= 1'b0;
            r_dma_src     <= '0;
            r_dma_dest    <= '0;
            r_count       <= '0;
            r_lat_type    <= '0;
            r_lat_opaque  <= '0;
            r_lat_domain  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_rdy    <= 1'b0;
                        r_lat_type   <= w_req_type;
                        r_lat_opaque <= w_req_opaque;
                        r_lat_domain <= req_domain;
                        if (w_go_write && !w_go_reject) begin
                            // Addresses are frozen here; no register write
                            // can occur until the response is consumed.
                            r_state      <= ST_LAUNCH;
                            r_dma_val    <= 1'b1;
                            r_dma_domain <= req_domain;
                            r_dma_src    <= w_reg_data[0];
                            r_dma_dest   <= w_reg_data[1];
                        end else begin
                            r_state       <= ST_RESP;
                            r_resp_val    <= 1'b1;
                            r_resp_data   <= w_resp_word;
                            r_resp_domain <= req_domain;
                            r_resp_type   <= w_req_type;
                            r_resp_opaque <= w_req_opaque;
                        end
                    end
                end
                ST_LAUNCH: begin
                    if (dma_rdy) begin
                        r_dma_val <= 1'b0;
                        r_state   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (dma_ack) begin
                        r_count       <= r_count + p_data_nbits'(1);
                        r_state       <= ST_RESP;
                        r_resp_val    <= 1'b1;
                        r_resp_data   <= status_word(STATUS_OK);
                        r_resp_domain <= r_lat_domain;
                        r_resp_type   <= r_lat_type;
                        r_resp_opaque <= r_lat_opaque;
                        r_dma_domain  <= 1'b0;
                        r_dma_src     <= '0;
                        r_dma_dest    <= '0;
                    end
                end
                ST_RESP: begin
                    if (resp_rdy) begin
                        r_state       <= ST_IDLE;
                        r_req_rdy     <= 1'b1;
                        r_resp_val    <= 1'b0;
                        r_resp_data   <= '0;
                        r_resp_domain <= 1'b0;
                        r_resp_type   <= '0;
                        r_resp_opaque <= '0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_req_rdy <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs; response pack is {type, opaque, len=0}
    // ------------------------------------------------------------------
    assign req_rdy       = r_req_rdy;
    assign resp_val      = r_resp_val;
    assign resp_data     = r_resp_data;
    assign resp_domain   = r_resp_domain;
    assign resp_control  = {r_resp_type, r_resp_opaque, {c_len_nbits{1'b0}}};
    assign dma_val       = r_dma_val;
    assign dma_domain    = r_dma_domain;
    assign dma_src_addr  = r_dma_src;
    assign dma_dest_addr = r_dma_dest;

endmodule
